decoder_pipe: RTL and testbench

//   Registered instruction-decode stage: decodes one MIPS instruction word per

---
 rtl/decoder_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_decoder_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_pipe.sv
// Registered MIPS instruction-decode stage with valid/ready flow control.
// Adds a HI/LO interlock that stalls multiplier-class instructions while a mult is in flight.
module decoder_pipe #(
  parameter int INSTR_W    = 32,
  parameter int REG_W      = 5,
  parameter int ALUCTRL_W  = 3,
  parameter int MUL_CYCLES = 4,
  parameter int LINK_REG   = 31
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 memtoreg,
  output logic                 memwrite,
  output logic                 isbranch,
  output logic                 branchne,
  output logic                 alusrcbimm,
  output logic                 immzext,
  output logic                 immupper,
  output logic [REG_W-1:0]     destreg,
  output logic                 regwrite,
  output logic                 dojump,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  // A zero-cycle multiplier still needs a 1-bit counter so the logic stays well-formed.
  localparam int CNT_W = (MUL_CYCLES > 0) ? $clog2(MUL_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_MFLO = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_MFHI = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(7);

  typedef struct packed {
    logic                 memtoreg;
    logic                 memwrite;
    logic                 isbranch;
    logic                 branchne;
    logic                 alusrcbimm;
    logic                 immzext;
    logic                 immupper;
    logic [REG_W-1:0]     destreg;
    logic                 regwrite;
    logic                 dojump;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 illegal;
  } ctrl_t;

  // Undefined encodings produce a harmless add with every side effect suppressed.
  function automatic ctrl_t illegal_ctrl();
    ctrl_t c;
    c            = '0;
    c.illegal    = 1'b1;
    c.alucontrol = ALU_ADD;
    return c;
  endfunction

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn,
                                   input logic [4:0] rt, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.regwrite = 1'b1;
        c.destreg  = REG_W'(rd);
        case (fn)
          FN_ADDU:           c.alucontrol = ALU_ADD;
          FN_SUBU:           c.alucontrol = ALU_SUB;
          FN_AND:            c.alucontrol = ALU_AND;
          FN_OR:             c.alucontrol = ALU_OR;
          FN_SLT:            c.alucontrol = ALU_SLT;
          FN_MULT, FN_MULTU: c.alucontrol = ALU_MUL;
          FN_MFLO:           c.alucontrol = ALU_MFLO;
          FN_MFHI:           c.alucontrol = ALU_MFHI;
          default:           c = illegal_ctrl();
        endcase
      end
      OP_LW: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.alusrcbimm = 1'b1;
        c.destreg    = REG_W'(rt);
        c.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        c.memwrite   = 1'b1;
        c.alusrcbimm = 1'b1;
        c.alucontrol = ALU_ADD;
      end
      OP_ADDIU, OP_LUI, OP_ORI: begin
        c.regwrite   = 1'b1;
        c.alusrcbimm = 1'b1;
        c.destreg    = REG_W'(rt);
        c.immupper   = (op == OP_LUI);
        c.immzext    = (op == OP_ORI);
        c.alucontrol = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        c.isbranch   = 1'b1;
        c.branchne   = op[0];
        c.alucontrol = ALU_SUB;
      end
      OP_J: begin
        c.dojump = 1'b1;
      end
      OP_JAL: begin
        c.dojump   = 1'b1;
        c.regwrite = 1'b1;
        c.destreg  = REG_W'(LINK_REG);
      end
      default: c = illegal_ctrl();
    endcase
    return c;
  endfunction

  logic [5:0]       op_p0;
  logic [5:0]       fn_p0;
  ctrl_t            ctrl_p0;
  logic             is_mult_p0;
  logic             is_hilo_p0;
  logic             hold;
  logic             accept;
  logic [CNT_W-1:0] mul_cnt;
  ctrl_t            ctrl_p1;
  logic             vld_p1;
  logic             unused_fields;

  assign op_p0         = instr[31:26];
  assign fn_p0         = instr[5:0];
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  assign ctrl_p0    = decode(op_p0, fn_p0, instr[20:16], instr[15:11]);
  assign is_mult_p0 = (op_p0 == OP_RTYPE) && ((fn_p0 == FN_MULT) || (fn_p0 == FN_MULTU));
  assign is_hilo_p0 = is_mult_p0 ||
                      ((op_p0 == OP_RTYPE) && ((fn_p0 == FN_MFLO) || (fn_p0 == FN_MFHI)));

  // Only multiplier-class instructions wait on the counter; everything else flows past.
  assign hold     = in_valid && (mul_cnt != '0) && is_hilo_p0;
  assign in_ready = reset_n && (!vld_p1 || out_ready) && !hold;
  assign accept   = in_valid && in_ready;

  // ---- stage p0 -> p1: output register and interlock counter ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      mul_cnt <= '0;
    end else begin
      if (accept) begin
        vld_p1  <= 1'b1;
        ctrl_p1 <= ctrl_p0;
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end

      if (accept && is_mult_p0) begin
        mul_cnt <= MUL_LOAD;
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - CNT_W'(1);
      end
    end
  end

  assign out_valid  = vld_p1;
  assign memtoreg   = ctrl_p1.memtoreg;
  assign memwrite   = ctrl_p1.memwrite;
  assign isbranch   = ctrl_p1.isbranch;
  assign branchne   = ctrl_p1.branchne;
  assign alusrcbimm = ctrl_p1.alusrcbimm;
  assign immzext    = ctrl_p1.immzext;
  assign immupper   = ctrl_p1.immupper;
  assign destreg    = ctrl_p1.destreg;
  assign regwrite   = ctrl_p1.regwrite;
  assign dojump     = ctrl_p1.dojump;
  assign alucontrol = ctrl_p1.alucontrol;
  assign illegal    = ctrl_p1.illegal;

endmodule

// File: tb/tb_decoder_pipe.sv
// Bench for decoder_pipe: directed scenarios plus randomized traffic against a
// mnemonic-level decode model with a single-entry output register and mult timer.
module tb_decoder_pipe;
  localparam int MUL_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic        in_ready, out_valid;
  logic        memtoreg, memwrite, isbranch, branchne, alusrcbimm, immzext, immupper;
  logic [4:0]  destreg;
  logic        regwrite, dojump, illegal;
  logic [2:0]  alucontrol;

  decoder_pipe #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .memtoreg(memtoreg), .memwrite(memwrite), .isbranch(isbranch),
    .branchne(branchne), .alusrcbimm(alusrcbimm), .immzext(immzext),
    .immupper(immupper), .destreg(destreg), .regwrite(regwrite),
    .dojump(dojump), .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  wire [17:0] obs = {memtoreg, memwrite, isbranch, branchne, alusrcbimm, immzext,
                     immupper, destreg, regwrite, dojump, alucontrol, illegal};

  // Expected bundle from instruction mnemonics, same field order as obs.
  function automatic logic [17:0] ref_decode(input logic [31:0] w);
    logic m2r, mw, br, bne, imm, zx, up, rw, jmp, ill;
    logic [4:0] dst;
    logic [2:0] alu;
    {m2r, mw, br, bne, imm, zx, up, rw, jmp, ill} = '0;
    dst = '0;
    alu = '0;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h21: alu = 3'd5;           // addu
          6'h23: alu = 3'd1;           // subu
          6'h24: alu = 3'd7;           // and
          6'h25: alu = 3'd6;           // or
          6'h2A: alu = 3'd0;           // slt
          6'h18, 6'h19: alu = 3'd4;    // mult
          6'h12: alu = 3'd2;           // mflo
          6'h10: alu = 3'd3;           // mfhi
          default: ill = 1'b1;
        endcase
        if (!ill) begin rw = 1'b1; dst = w[15:11]; end
      end
      6'h23: begin rw = 1'b1; m2r = 1'b1; imm = 1'b1; dst = w[20:16]; alu = 3'd5; end
      6'h2B: begin mw = 1'b1; imm = 1'b1; alu = 3'd5; end
      6'h09: begin rw = 1'b1; imm = 1'b1; dst = w[20:16]; alu = 3'd5; end
      6'h0F: begin rw = 1'b1; imm = 1'b1; up = 1'b1; dst = w[20:16]; alu = 3'd5; end
      6'h0D: begin rw = 1'b1; imm = 1'b1; zx = 1'b1; dst = w[20:16]; alu = 3'd6; end
      6'h04: begin br = 1'b1; alu = 3'd1; end
      6'h05: begin br = 1'b1; bne = 1'b1; alu = 3'd1; end
      6'h02: jmp = 1'b1;
      6'h03: begin jmp = 1'b1; rw = 1'b1; dst = 5'd31; end
      default: ill = 1'b1;
    endcase
    if (ill) alu = 3'd5;
    return {m2r, mw, br, bne, imm, zx, up, dst, rw, jmp, alu, ill};
  endfunction

  function automatic bit is_mult(input logic [31:0] w);
    return (w[31:26] == 6'h00) && (w[5:0] == 6'h18 || w[5:0] == 6'h19);
  endfunction

  function automatic bit is_hilo(input logic [31:0] w);
    return is_mult(w) || ((w[31:26] == 6'h00) && (w[5:0] == 6'h12 || w[5:0] == 6'h10));
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; instr = 32'h00221821; out_ready = 1'b1;
    step(); step(); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (obs !== 18'h0) begin errors++; $display("FAIL reset_bundle got %h want 0", obs); end
    reset_n = 1'b1; in_valid = 1'b0;
    step();
  endtask

  task automatic test_addu_b2b();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00221821; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addu_ready got %b want 1", in_ready); end
    step();
    instr = 32'h00222823; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    checks++; if ({out_valid, regwrite, destreg, alucontrol, illegal} !== {1'b1, 1'b1, 5'd3, 3'b101, 1'b0})
      begin errors++; $display("FAIL addu_bundle got v%b rw%b d%0d alu%b ill%b want v1 rw1 d3 alu101 ill0", out_valid, regwrite, destreg, alucontrol, illegal); end
    step();
    instr = 32'h00223824; #1;
    checks++; if ({out_valid, destreg, alucontrol} !== {1'b1, 5'd5, 3'b001})
      begin errors++; $display("FAIL subu_bundle got v%b d%0d alu%b want v1 d5 alu001", out_valid, destreg, alucontrol); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out_valid, destreg, alucontrol} !== {1'b1, 5'd7, 3'b111})
      begin errors++; $display("FAIL and_bundle got v%b d%0d alu%b want v1 d7 alu111", out_valid, destreg, alucontrol); end
    step(); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b0; instr = 32'h00223025; #1;
    step();
    instr = 32'h8C220004; #1;
    for (int i = 0; i < 2; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b want 0", i, in_ready); end
      checks++; if ({out_valid, destreg, alucontrol, memtoreg} !== {1'b1, 5'd6, 3'b110, 1'b0})
        begin errors++; $display("FAIL stall_hold[%0d] got v%b d%0d alu%b m2r%b want v1 d6 alu110 m2r0", i, out_valid, destreg, alucontrol, memtoreg); end
      step();
    end
    out_ready = 1'b1; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out_valid, memtoreg, destreg, alusrcbimm, regwrite, alucontrol} !== {1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 3'b101})
      begin errors++; $display("FAIL lw_bundle got v%b m2r%b d%0d imm%b rw%b alu%b want v1 m2r1 d2 imm1 rw1 alu101", out_valid, memtoreg, destreg, alusrcbimm, regwrite, alucontrol); end
    step();
  endtask

  task automatic test_interlock();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00220019; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready got %b want 1", in_ready); end
    step();
    instr = 32'h00002012; #1;
    checks++; if ({out_valid, alucontrol} !== {1'b1, 3'b100})
      begin errors++; $display("FAIL mult_bundle got v%b alu%b want v1 alu100", out_valid, alucontrol); end
    for (int i = 0; i < MUL_CYCLES; i++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mflo_hold[%0d] got %b want 0", i, in_ready); end
      step();
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mflo_release got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out_valid, alucontrol, destreg} !== {1'b1, 3'b010, 5'd4})
      begin errors++; $display("FAIL mflo_bundle got v%b alu%b d%0d want v1 alu010 d4", out_valid, alucontrol, destreg); end
    step();
  endtask

  task automatic test_ctrl_flow();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'h0C000010; #1;
    step();
    instr = 32'h14220003; #1;
    checks++; if ({dojump, regwrite, destreg, isbranch} !== {1'b1, 1'b1, 5'd31, 1'b0})
      begin errors++; $display("FAIL jal_bundle got j%b rw%b d%0d br%b want j1 rw1 d31 br0", dojump, regwrite, destreg, isbranch); end
    step();
    instr = 32'h3C011234; #1;
    checks++; if ({isbranch, branchne, alucontrol, regwrite, dojump} !== {1'b1, 1'b1, 3'b001, 1'b0, 1'b0})
      begin errors++; $display("FAIL bne_bundle got br%b bne%b alu%b rw%b j%b want br1 bne1 alu001 rw0 j0", isbranch, branchne, alucontrol, regwrite, dojump); end
    step();
    instr = 32'h34220FF0; #1;
    checks++; if ({immupper, immzext, regwrite, alusrcbimm, destreg} !== {1'b1, 1'b0, 1'b1, 1'b1, 5'd1})
      begin errors++; $display("FAIL lui_bundle got up%b zx%b rw%b imm%b d%0d want up1 zx0 rw1 imm1 d1", immupper, immzext, regwrite, alusrcbimm, destreg); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({immzext, immupper, alucontrol, destreg} !== {1'b1, 1'b0, 3'b110, 5'd2})
      begin errors++; $display("FAIL ori_bundle got zx%b up%b alu%b d%0d want zx1 up0 alu110 d2", immzext, immupper, alucontrol, destreg); end
    step();
  endtask

  task automatic test_illegal_reset();
    in_valid = 1'b1; out_ready = 1'b1; instr = 32'hFC000000; #1;
    step();
    instr = 32'h00220019; #1;
    checks++; if ({illegal, regwrite, memwrite, isbranch, dojump, alucontrol} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101})
      begin errors++; $display("FAIL illegal_bundle got ill%b rw%b mw%b br%b j%b alu%b want ill1 rw0 mw0 br0 j0 alu101", illegal, regwrite, memwrite, isbranch, dojump, alucontrol); end
    step();
    instr = 32'h00002012; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_hold got %b want 0", in_ready); end
    step();
    reset_n = 1'b0; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL in_reset_ready got %b want 0", in_ready); end
    step();
    reset_n = 1'b1; #1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL post_reset got rdy%b v%b want rdy1 v0", in_ready, out_valid); end
    step();
    in_valid = 1'b0; #1;
    checks++; if ({out_valid, alucontrol, destreg} !== {1'b1, 3'b010, 5'd4})
      begin errors++; $display("FAIL post_reset_mflo got v%b alu%b d%0d want v1 alu010 d4", out_valid, alucontrol, destreg); end
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          k;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    k = int'($urandom_range(0, 15));
    case (k)
      0, 1, 2, 3: begin
        case ($urandom_range(0, 12))
          0: fn = 6'h21;  1: fn = 6'h23;  2: fn = 6'h24;  3: fn = 6'h25;
          4: fn = 6'h2A;  5: fn = 6'h18;  6: fn = 6'h19;  7, 8: fn = 6'h12;
          9, 10: fn = 6'h10;  11: fn = 6'h20;  default: fn = 6'h08;
        endcase
        return {6'h00, rs, rt, rd, 5'd0, fn};
      end
      4: return {6'h23, rs, rt, imm};
      5: return {6'h2B, rs, rt, imm};
      6: return {6'h09, rs, rt, imm};
      7: return {6'h0F, 5'd0, rt, imm};
      8: return {6'h0D, rs, rt, imm};
      9: return {6'h04, rs, rt, imm};
      10: return {6'h05, rs, rt, imm};
      11: return {6'h02, 26'($urandom)};
      12: return {6'h03, 26'($urandom)};
      13: return {6'h3F, 26'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    bit          exp_vld;
    logic [17:0] exp_b;
    int          last_mult;
    bit          hold, exp_rdy, acc;
    logic [31:0] w;
    reset_n = 1'b0; in_valid = 1'b0; step();
    reset_n = 1'b1;
    exp_vld = 1'b0; exp_b = '0; last_mult = -1000;
    for (int i = 0; i < 600; i++) begin
      w = rand_instr();
      in_valid = ($urandom_range(0, 3) != 0);
      instr = w;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      hold = in_valid && is_hilo(w) && (cyc - last_mult < MUL_CYCLES);
      exp_rdy = (!exp_vld || out_ready) && !hold;
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", i, in_ready, exp_rdy); end
      checks++; if (out_valid !== exp_vld) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %b", i, out_valid, exp_vld); end
      if (exp_vld) begin
        checks++; if (obs !== exp_b) begin errors++; $display("FAIL rnd_bundle[%0d] got %h want %h", i, obs, exp_b); end
      end
      acc = in_valid && exp_rdy;
      @(posedge clk);
      cyc++;
      if (acc) begin
        exp_vld = 1'b1;
        exp_b = ref_decode(w);
        if (is_mult(w)) last_mult = cyc;
      end else if (out_ready) begin
        exp_vld = 1'b0;
      end
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addu_b2b();
    test_backpressure();
    test_interlock();
    test_ctrl_flow();
    test_illegal_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
